// File: rtl/interconnect_fabric.sv
// Single-master interconnect: decodes CPU requests to one of N_TGT targets or a
// boot shadow ROM, with per-access timeout and a saturating error counter.
module interconnect_fabric #(
    parameter int                      ADDR_W      = 16,
    parameter int                      DATA_W      = 16,
    parameter int                      N_TGT       = 4,
    parameter logic [N_TGT*ADDR_W-1:0] TGT_BASE    = {16'hF000, 16'hE000, 16'h0000, 16'h0000},
    parameter logic [N_TGT*ADDR_W-1:0] TGT_MASK    = {16'hFF00, 16'hF000, 16'hE000, 16'hC000},
    parameter int                      TIMEOUT     = 255,
    parameter int                      SHADOW_LOG2 = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    boot_sel,
    input  logic                    cpu_mem_req,
    input  logic                    cpu_mem_read,
    input  logic                    cpu_mem_write,
    input  logic [ADDR_W-1:0]       cpu_mem_addr,
    input  logic [DATA_W-1:0]       cpu_mem_wdata,
    output logic [DATA_W-1:0]       cpu_mem_rdata,
    output logic                    cpu_mem_ready,
    output logic                    cpu_mem_err,
    output logic [N_TGT-1:0]        tgt_req,
    output logic                    tgt_we,
    output logic [ADDR_W-1:0]       tgt_addr,
    output logic [DATA_W-1:0]       tgt_wdata,
    input  logic [N_TGT*DATA_W-1:0] tgt_rdata,
    input  logic [N_TGT-1:0]        tgt_ready,
    output logic [SHADOW_LOG2-1:0]  rom_addr,
    input  logic [DATA_W-1:0]       rom_data,
    output logic                    boot_mode,
    output logic [7:0]              err_count
);

    localparam int IDX_W = (N_TGT > 1) ? $clog2(N_TGT) : 1;
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        SHADOW,
        RESP
    } state_t;

    state_t             state;
    state_t             next_state;

    logic               boot_done;
    logic               armed;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               we_q;
    logic [IDX_W-1:0]   sel_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               err_q;
    logic [CNT_W-1:0]   to_cnt;

    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic               shadow_hit;
    logic               rw_bad;
    logic               accept;
    logic               sel_ready;
    logic               timed_out;
    logic [DATA_W-1:0]  tgt_rdata_arr [N_TGT];

    // Address decode; scanning from the top down lets the lowest index win.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_TGT - 1; i >= 0; i--) begin
            if ((cpu_mem_addr & TGT_MASK[i*ADDR_W +: ADDR_W]) == TGT_BASE[i*ADDR_W +: ADDR_W]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign rw_bad     = (cpu_mem_read == cpu_mem_write);
    assign shadow_hit = boot_mode && cpu_mem_read && !cpu_mem_write &&
                        (cpu_mem_addr[ADDR_W-1:SHADOW_LOG2] == '0);
    assign accept     = (state == IDLE) && cpu_mem_req && armed;

    always_comb begin
        for (int i = 0; i < N_TGT; i++) begin
            tgt_rdata_arr[i] = tgt_rdata[i*DATA_W +: DATA_W];
        end
    end

    assign sel_ready = tgt_ready[sel_q];
    assign timed_out = (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (rw_bad) begin
                        next_state = RESP;
                    end else if (shadow_hit) begin
                        next_state = SHADOW;
                    end else if (hit) begin
                        next_state = ACCESS;
                    end else begin
                        next_state = RESP;
                    end
                end
            end
            ACCESS: begin
                if (sel_ready || timed_out) begin
                    next_state = RESP;
                end
            end
            SHADOW:  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        tgt_req       = '0;
        cpu_mem_ready = 1'b0;
        cpu_mem_err   = 1'b0;
        case (state)
            ACCESS: tgt_req[sel_q] = 1'b1;
            RESP: begin
                cpu_mem_ready = 1'b1;
                cpu_mem_err   = err_q;
            end
            default: ;
        endcase
    end

    assign cpu_mem_rdata = rdata_q;
    assign tgt_we        = we_q;
    assign tgt_addr      = addr_q;
    assign tgt_wdata     = wdata_q;
    assign rom_addr      = addr_q[SHADOW_LOG2-1:0];

    // Boot source is sampled once, on the first edge out of reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            boot_mode <= 1'b0;
            boot_done <= 1'b0;
        end else if (!boot_done) begin
            boot_mode <= boot_sel;
            boot_done <= 1'b1;
        end
    end

    // A held request must drop for an IDLE cycle before another one is taken.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            armed   <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
        end else begin
            if (state == IDLE && !cpu_mem_req) begin
                armed <= 1'b1;
            end
            if (accept) begin
                armed   <= 1'b0;
                addr_q  <= cpu_mem_addr;
                wdata_q <= cpu_mem_wdata;
                we_q    <= cpu_mem_write;
                sel_q   <= hit_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
            to_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        to_cnt <= '0;
                        if (rw_bad || (!shadow_hit && !hit)) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    // A ready in the last allowed cycle still completes normally.
                    if (sel_ready) begin
                        rdata_q <= we_q ? '0 : tgt_rdata_arr[sel_q];
                        err_q   <= 1'b0;
                    end else if (timed_out) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                SHADOW: begin
                    rdata_q <= rom_data;
                    err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_count <= 8'h00;
        end else if (state == RESP && err_q && err_count != 8'hFF) begin
            err_count <= err_count + 8'h01;
        end
    end

endmodule

// File: tb/tb_interconnect_fabric.sv
// Randomized scoreboard bench for interconnect_fabric against a transaction-level
// model of the decode map, shadow ROM, target handshake and timeout rules.
module tb_interconnect_fabric;

    localparam int TO = 4;
    localparam logic [15:0] BASE [4] = '{16'h0000, 16'h0000, 16'hE000, 16'hF000};
    localparam logic [15:0] MASK [4] = '{16'hC000, 16'hE000, 16'hF000, 16'hFF00};

    logic        clk = 1'b0;
    logic        reset_n;
    logic        boot_sel;
    logic        cpu_mem_req;
    logic        cpu_mem_read;
    logic        cpu_mem_write;
    logic [15:0] cpu_mem_addr;
    logic [15:0] cpu_mem_wdata;
    logic [15:0] cpu_mem_rdata;
    logic        cpu_mem_ready;
    logic        cpu_mem_err;
    logic [3:0]  tgt_req;
    logic        tgt_we;
    logic [15:0] tgt_addr;
    logic [15:0] tgt_wdata;
    logic [63:0] tgt_rdata;
    logic [3:0]  tgt_ready;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        boot_mode;
    logic [7:0]  err_count;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    bit   exp_boot;
    int   exp_ec;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rom_data = {8'h00, rom_addr} ^ 16'h00A0;

    interconnect_fabric #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .boot_sel(boot_sel),
        .cpu_mem_req(cpu_mem_req), .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
        .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata), .cpu_mem_rdata(cpu_mem_rdata),
        .cpu_mem_ready(cpu_mem_ready), .cpu_mem_err(cpu_mem_err),
        .tgt_req(tgt_req), .tgt_we(tgt_we), .tgt_addr(tgt_addr), .tgt_wdata(tgt_wdata),
        .tgt_rdata(tgt_rdata), .tgt_ready(tgt_ready),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .boot_mode(boot_mode), .err_count(err_count)
    );

    task automatic check_output(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Returns -2 for an error response, -1 for a shadow ROM read, else the target index.
    function automatic int decode(input logic rd, input logic wr, input logic [15:0] a);
        if (rd == wr) return -2;
        if (exp_boot && rd && a < 16'h0100) return -1;
        for (int i = 0; i < 4; i++) begin
            if ((a & MASK[i]) == BASE[i]) return i;
        end
        return -2;
    endfunction

    // Monitor: every completion pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (cpu_mem_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_output("unexpected_ready", cpu_mem_ready, 1'b0);
            end else begin
                e = sb_q.pop_front();
                check_output("rdata", cpu_mem_rdata, e.rdata);
                check_output("err", cpu_mem_err, e.err);
                check_output("latency", cyc - e.acc + 1, e.lat);
            end
        end else begin
            check_output("err_idle", cpu_mem_err, 1'b0);
        end
    end

    task automatic reset_dut(input bit bs);
        cpu_mem_req   = 1'b0;
        cpu_mem_read  = 1'b0;
        cpu_mem_write = 1'b0;
        cpu_mem_addr  = '0;
        cpu_mem_wdata = '0;
        tgt_ready     = '0;
        tgt_rdata     = '0;
        boot_sel      = bs;
        reset_n       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_outputs", {cpu_mem_ready, cpu_mem_err, cpu_mem_rdata, tgt_req}, '0);
        check_output("reset_state", {err_count, boot_mode, tgt_addr, tgt_wdata}, '0);
        sb_q.delete();
        @(posedge clk); #1;
        reset_n  = 1'b1;
        exp_ec   = 0;
        exp_boot = bs;
        @(posedge clk); #1;
        check_output("boot_capture", boot_mode, bs);
        boot_sel = ~bs;
        @(posedge clk); #1;
        check_output("boot_hold", boot_mode, bs);
    endtask

    // delay = ACCESS cycle in which the target answers; 0 means it never answers.
    task automatic apply_stimulus(input logic rd, input logic wr, input logic [15:0] a,
                                  input logic [15:0] wd, input int delay, input bit hold);
        int         kind;
        exp_t       e;
        logic [3:0] onehot;
        int         req_cycles;
        int         exp_req;
        bit         done;
        bit         ok;

        @(posedge clk); #1;
        cpu_mem_req = 1'b0;
        kind      = decode(rd, wr, a);
        tgt_rdata = {$urandom, $urandom};
        onehot    = (kind >= 0) ? (4'b0001 << kind) : 4'b0000;
        ok        = (delay >= 1 && delay <= TO);
        exp_req   = (kind >= 0) ? (ok ? delay : TO) : 0;
        if (kind == -2) begin
            e.rdata = '0; e.err = 1'b1; e.lat = 1;
        end else if (kind == -1) begin
            e.rdata = {8'h00, a[7:0]} ^ 16'h00A0; e.err = 1'b0; e.lat = 2;
        end else begin
            e.err   = !ok;
            e.rdata = (!ok || wr) ? 16'h0000 : tgt_rdata[kind*16 +: 16];
            e.lat   = exp_req + 1;
        end

        @(posedge clk); #1;
        cpu_mem_req   = 1'b1;
        cpu_mem_read  = rd;
        cpu_mem_write = wr;
        cpu_mem_addr  = a;
        cpu_mem_wdata = wd;
        @(posedge clk); #1;
        e.acc = cyc;
        sb_q.push_back(e);
        if (!hold) cpu_mem_req = 1'b0;
        cpu_mem_addr  = 16'($urandom);
        cpu_mem_wdata = 16'($urandom);

        req_cycles = 0;
        done = 1'b0;
        for (int k = 1; k <= 20 && !done; k++) begin
            tgt_ready = 4'($urandom) & ~onehot;
            if (kind >= 0 && k == delay) tgt_ready = tgt_ready | onehot;
            @(negedge clk);
            if (tgt_req !== 4'b0000) begin
                req_cycles++;
                check_output("tgt_bus", {tgt_req, tgt_we, tgt_addr, tgt_wdata}, {onehot, wr, a, wd});
            end
            if (kind == -1 && k == 1) check_output("rom_addr", rom_addr, a[7:0]);
            if (cpu_mem_ready === 1'b1) begin
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!done) check_output("ready_seen", cpu_mem_ready, 1'b1);
        tgt_ready = '0;
        check_output("req_cycles", req_cycles, exp_req);
        exp_ec = (exp_ec + int'(e.err) > 255) ? 255 : exp_ec + int'(e.err);

        if (hold) begin
            repeat (3) begin
                @(posedge clk); #1;
                @(negedge clk);
                check_output("hold_quiet", {cpu_mem_ready, tgt_req}, '0);
            end
        end
        @(posedge clk); #1;
        cpu_mem_req = 1'b0;
        check_output("err_count", err_count, exp_ec[7:0]);
    endtask

    task automatic random_txn();
        logic [15:0] a;
        logic        rd;
        logic        wr;
        int          r;
        case ($urandom_range(0, 5))
            0:       a = 16'($urandom);
            1:       a = 16'($urandom_range(0, 255));
            2:       a = 16'hE000 | 16'($urandom_range(0, 16'h0FFF));
            3:       a = 16'hF000 | 16'($urandom_range(0, 16'h00FF));
            4:       a = 16'hF100 + 16'($urandom_range(0, 16'h0EFF));
            default: a = 16'($urandom_range(16'h4000, 16'hDFFF));
        endcase
        r = $urandom_range(0, 9);
        if (r < 5) begin
            rd = 1'b1; wr = 1'b0;
        end else if (r < 9) begin
            rd = 1'b0; wr = 1'b1;
        end else begin
            rd = 1'($urandom); wr = rd;
        end
        apply_stimulus(rd, wr, a, 16'($urandom), $urandom_range(0, 6), 1'b0);
    endtask

    initial begin
        reset_dut(1'b1);
        apply_stimulus(1'b1, 1'b0, 16'h0005, 16'h0000, 0, 1'b0);

        reset_dut(1'b0);
        apply_stimulus(1'b0, 1'b1, 16'hF010, 16'h1234, 3, 1'b0);
        apply_stimulus(1'b1, 1'b0, 16'h2000, 16'h0000, 0, 1'b0);

        reset_dut(1'b0);
        apply_stimulus(1'b1, 1'b0, 16'hF800, 16'h0000, 1, 1'b0);
        apply_stimulus(1'b1, 1'b1, 16'h0000, 16'h0000, 1, 1'b0);

        apply_stimulus(1'b1, 1'b0, 16'hE004, 16'h0000, 2, 1'b1);
        apply_stimulus(1'b1, 1'b0, 16'h1234, 16'h0000, TO, 1'b0);
        apply_stimulus(1'b0, 1'b1, 16'h0ABC, 16'h5A5A, TO + 1, 1'b0);

        // Reset in the middle of a target access abandons it.
        reset_dut(1'b0);
        @(posedge clk); #1;
        cpu_mem_req = 1'b1; cpu_mem_read = 1'b1; cpu_mem_write = 1'b0; cpu_mem_addr = 16'h2000;
        @(posedge clk); #1;
        cpu_mem_req = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(negedge clk);
        check_output("pre_reset_req", tgt_req, 4'b0001);
        @(posedge clk); #1;
        check_output("reset_drop_req", tgt_req, 4'b0000);
        check_output("reset_err_count", err_count, 8'h00);
        reset_dut(1'b0);

        for (int b = 0; b < 2; b++) begin
            reset_dut(b[0]);
            repeat (60) random_txn();
        end

        reset_dut(1'b0);
        for (int n = 0; n < 260; n++) begin
            if (n % 2 == 0) apply_stimulus(1'b0, 1'b0, 16'($urandom), 16'h0000, 0, 1'b0);
            else            apply_stimulus(1'b1, 1'b0, 16'hF800, 16'h0000, 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", n_errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
